// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The requester drives start/sub/a/b through the master modport;
// the arithmetic block returns busy/done and the registered results.
interface serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_s;
    logic             o_co;
    logic             o_ovf;

    modport master (
        output i_start, i_sub, i_a, i_b,
        input  o_busy, o_done, o_s, o_co, o_ovf
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b,
        output o_busy, o_done, o_s, o_co, o_ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice, a carry flop and
// operand shift registers, one bit per clock, LSB first.
// Subtraction is a + ~b + 1, the +1 entering as the initial carry.
// Optional build macro SERIAL_ADDSUB_SAT_EN: when defined, a signed overflow
// saturates o_s to the most positive / most negative value; when undefined
// o_s is the wrapped two's-complement result.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    serial_addsub_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   res_sh;     // sum bits gathered so far, newest at the top
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   s_q;
    logic               co_q;
    logic               ovf_q;

    logic               fa_sum;
    logic               fa_co;
    logic [WIDTH-1:0]   res_next;
    logic               ovf_next;
    logic [WIDTH-1:0]   final_s;

    // The single full-adder slice working on the current LSBs.
    assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_co    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign res_next = {fa_sum, res_sh};

    // On the final bit, carry holds the carry into the MSB.
    assign ovf_next = carry ^ fa_co;

`ifdef SERIAL_ADDSUB_SAT_EN
    // Overflow needs equal effective operand MSBs; a 0 MSB means the true
    // result was positive, so clamp to 0111..1, otherwise to 1000..0.
    assign final_s = !ovf_next ? res_next :
                     (a_sh[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign final_s = res_next;
`endif

    assign bus.o_busy = busy;
    assign bus.o_done = done;
    assign bus.o_s    = s_q;
    assign bus.o_co   = co_q;
    assign bus.o_ovf  = ovf_q;

    // Control FSM plus datapath: load on start, shift one bit per clock,
    // publish the results and pulse done on the terminal count.
    // NOTE: every register here is assigned with <= so all of them sample the
    // pre-edge values; a blocking '=' would let later statements see
    // already-shifted operands and corrupt the serial sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            s_q    <= '0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        a_sh  <= bus.i_a;
                        b_sh  <= bus.i_sub ? ~bus.i_b : bus.i_b;
                        carry <= bus.i_sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next[WIDTH-1:1];
                    carry  <= fa_co;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        s_q   <= final_s;
                        co_q  <= fa_co;
                        ovf_q <= ovf_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor with one full-adder slice, a carry flip-flop and operand shift registers.
- Processes one bit per clock, LSB first.
- Area-minimal counterpart to the parallel ripple-carry adder. The ripple-carry adder's testbench only drives it; this block consumes operands through a start/done handshake and produces the sum (or difference).
- Intended as the arithmetic back end for small sequential datapaths and as a cross-check reference for the RCA.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- i_start  input  1  request; sampled only in IDLE
- i_sub  input  1  0 = a+b, 1 = a-b; sampled with i_start
- i_a  input  WIDTH  operand A; sampled with i_start
- i_b  input  WIDTH  operand B; sampled with i_start
- o_busy  output  1  high while a computation is in progress
- o_done  output  1  one-cycle pulse when results are valid
- o_s  output  WIDTH  sum/difference, two's complement
- o_co  output  1  carry out; for subtract, 1 = no borrow (A >= B unsigned)
- o_ovf  output  1  signed overflow

Behaviour:
- One clock domain; reset is asynchronous, active-low.
- Reset values: state = IDLE, o_busy = 0, o_done = 0, o_s = 0, o_co = 0, o_ovf = 0. Internal shift registers, carry and counter are all cleared.
- States: IDLE, RUN.
- IDLE with i_start = 1 at edge E0:
  - Load A into the shift register.
  - Load B, or ~B when i_sub = 1, into its shift register.
  - Set carry = i_sub.
  - Clear the bit counter; go to RUN; o_busy = 1 after E0.
- RUN, each edge:
  - Full-adder sum of A[0], B[0] and carry shifts into the result register MSB.
  - Carry register takes the FA carry-out.
  - Operands shift right; counter increments.
- Final bit at edge E_WIDTH:
  - o_s, o_co and o_ovf update.
  - o_ovf = carry into MSB XOR carry out of MSB.
  - o_done = 1 for exactly one cycle (the cycle after E_WIDTH); o_busy = 0; state returns to IDLE.
- Latency: start to o_done = WIDTH cycles; the next start is accepted in the o_done cycle (back-to-back throughput of one op per WIDTH cycles).
- o_s, o_co and o_ovf hold their last values until the next completion. They do not change during RUN; a separate result register is updated only at completion.
- i_start in RUN is ignored: no queueing, no restart. i_a, i_b and i_sub may change freely after E0.
- Wrap-around: unsigned results are modulo 2^WIDTH; the carry is reported only via o_co.
- Reset asserted mid-RUN: immediate return to the reset values; no o_done pulse is emitted.
- The counter is sized for WIDTH and terminal count is WIDTH-1. No state other than IDLE/RUN is reachable; a default branch goes to IDLE.

Optional Feature:
- Macro SERIAL_ADDSUB_SAT_EN.
- Defined: when signed overflow occurs, o_s saturates.
  - Positive overflow (operand MSBs imply a positive result) gives 0111..1.
  - Negative overflow gives 1000..0.
  - o_ovf is still reported; o_co is unchanged.
- Undefined: o_s is the wrapped two's-complement result. No saturation logic is present.

Test Plan:
- WIDTH=4, a=3, b=5, sub=0 -> o_done 4 cycles after start; o_s=1000, o_co=0, o_ovf=1 (with SAT_EN: o_s=0111).
- a=7, b=2, sub=1 -> o_s=0101, o_co=1, o_ovf=0; a=2, b=7, sub=1 -> o_s=1011, o_co=0, o_ovf=0.
- a=15, b=1, sub=0 -> o_s=0000, o_co=1, o_ovf=0. Then exhaustively sweep all 16x16x2 cases against an a±b model.
- Start a=1, b=1; pulse i_start again with a=9, b=9 two cycles later -> second start ignored; o_s=0010 at done; o_busy stays high for exactly 4 cycles.
- Drop reset_n mid-RUN (after 2 bits) -> all outputs 0 immediately, no o_done. Restart a=6, b=6 -> o_s=1100, o_ovf=1.
- Back-to-back: assert i_start during the o_done cycle -> the new op completes exactly 4 cycles later; the previous o_s holds until then.
